// File: rtl/jtag_dbg_pkg.sv
// Shared defaults and the command record for the JTAG debug command synchroniser.
package jtag_dbg_pkg;

  localparam int DEF_SR_W        = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEPTH       = 4;

  // Command record at the default widths: virtual IR above shifted data.
  // The FIFO declares the same layout at its own parameterised widths.
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/jtag_dbg_cmd_fifo.sv
// Command FIFO: storage, wrap-around pointers, occupancy and sticky overflow.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module jtag_dbg_cmd_fifo
  import jtag_dbg_pkg::*;
#(
  parameter int SR_W  = DEF_SR_W,
  parameter int IR_W  = DEF_IR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [IR_W-1:0]  push_ir,
  input  logic [SR_W-1:0]  push_data,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic             valid,
  output logic [IR_W-1:0]  head_ir,
  output logic [SR_W-1:0]  head_data,
  output logic             pop_ok,
  output logic             overflow,
  output logic [LVL_W-1:0] level
);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             overflow_reg;
  logic             full;
  logic             push_ok;
  logic             ovf_event;

  assign valid     = (level_reg != '0);
  assign full      = (level_reg == LVL_W'(DEPTH));
  assign pop_ok    = pop & valid;
  assign push_ok   = push & (~full | pop_ok);
  assign ovf_event = push & full & ~pop_ok;

  // Head is read straight from storage; outputs read as zero while empty
  // so stale or flushed entries never show on the ports.
  assign head      = mem[rd_ptr_reg];
  assign head_ir   = valid ? head.ir   : '0;
  assign head_data = valid ? head.data : '0;
  assign overflow  = overflow_reg;
  assign level     = level_reg;

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {push_ir, push_data};
  end

  // Pointers, occupancy and sticky overflow (overflow event beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
      if (ovf_event)    overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Brings JTAG update-IR / update-DR strobes into the clk domain, queues
// {ir, sr} commands and decodes popped commands into per-channel pulses.
module jtag_debug_cmd_sync
  import jtag_dbg_pkg::*;
#(
  parameter int SR_W        = DEF_SR_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ACT_BIT     = SR_W - 1,
  localparam int NCH        = 2 ** IR_W,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [SR_W-1:0]  sr,
  input  logic             vs_uir,
  input  logic             vs_udr,
  input  logic             cmd_ready,
  input  logic             ovf_clr,
  output logic             cmd_valid,
  output logic [IR_W-1:0]  cmd_ir,
  output logic [SR_W-1:0]  jdo,
  output logic [NCH-1:0]   take_action,
  output logic [NCH-1:0]   take_no_action,
  output logic             overflow,
  output logic [LVL_W-1:0] level
);

  logic [SYNC_STAGES-1:0] prime_reg;
  logic                   primed;
  logic [1:0]             strobe;
  logic [1:0]             rise;
  logic [IR_W-1:0]        ir_q_reg;
  logic                   pop;
  logic                   pop_ok;
  logic [NCH-1:0]         pop_sel;
  logic [NCH-1:0]         take_action_reg;
  logic [NCH-1:0]         take_no_action_reg;

  assign strobe = {vs_udr, vs_uir};

  // Fills with ones after reset; until the last bit is set the synchroniser
  // outputs still hold reset values, so a strobe held high across reset
  // release is treated as already high rather than as a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime_reg <= '0;
    else          prime_reg <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
  end

  assign primed = prime_reg[SYNC_STAGES-1];

  // Index 0 handles vs_uir, index 1 handles vs_udr.
  for (genvar gi = 0; gi < 2; gi++) begin : g_strobe
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    // Synchroniser chain, previous-level flop and registered rising-edge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_reg <= '0;
        prev_reg <= 1'b0;
        rise_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], strobe[gi]};
        prev_reg <= primed ? sync_reg[SYNC_STAGES-1] : 1'b1;
        rise_reg <= primed & sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end
    end

    assign rise[gi] = rise_reg;
  end

  // Latch the virtual IR; a push in the same cycle still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ir_q_reg <= '0;
    else if (rise[0]) ir_q_reg <= ir_in;
  end

  assign pop = cmd_valid & cmd_ready;

  jtag_dbg_cmd_fifo #(
    .SR_W (SR_W),
    .IR_W (IR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rise[1]),
    .push_ir  (ir_q_reg),
    .push_data(sr),
    .pop      (pop),
    .ovf_clr  (ovf_clr),
    .valid    (cmd_valid),
    .head_ir  (cmd_ir),
    .head_data(jdo),
    .pop_ok   (pop_ok),
    .overflow (overflow),
    .level    (level)
  );

  // One-hot channel select of the head command.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
    assign pop_sel[gi] = (cmd_ir == IR_W'(gi));
  end

  // Pulse the popped command's channel for one cycle on the action or
  // no-action vector, chosen by the head's action bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      take_action_reg    <= '0;
      take_no_action_reg <= '0;
    end else begin
      take_action_reg    <= (pop_ok &&  jdo[ACT_BIT]) ? pop_sel : '0;
      take_no_action_reg <= (pop_ok && !jdo[ACT_BIT]) ? pop_sel : '0;
    end
  end

  assign take_action    = take_action_reg;
  assign take_no_action = take_no_action_reg;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed-plus-random bench for jtag_debug_cmd_sync at default parameters.
// The model is a command queue plus a latched IR and a sticky overflow flag.
module tb_jtag_debug_cmd_sync;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [IR_W-1:0]  ir_in = '0;
  logic [SR_W-1:0]  sr = '0;
  logic             vs_uir = 1'b0;
  logic             vs_udr = 1'b0;
  logic             cmd_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             cmd_valid;
  logic [IR_W-1:0]  cmd_ir;
  logic [SR_W-1:0]  jdo;
  logic [NCH-1:0]   take_action;
  logic [NCH-1:0]   take_no_action;
  logic             overflow;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  jtag_debug_cmd_sync dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_in         (ir_in),
    .sr            (sr),
    .vs_uir        (vs_uir),
    .vs_udr        (vs_udr),
    .cmd_ready     (cmd_ready),
    .ovf_clr       (ovf_clr),
    .cmd_valid     (cmd_valid),
    .cmd_ir        (cmd_ir),
    .jdo           (jdo),
    .take_action   (take_action),
    .take_no_action(take_no_action),
    .overflow      (overflow),
    .level         (level)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state.
  logic [IR_W+SR_W-1:0] model_q[$];
  logic [IR_W-1:0]      model_irq = '0;
  logic                 model_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    return {6'($urandom), $urandom};
  endfunction

  // Channel pulse expected for a command: bit ir set when action matches.
  function automatic logic [NCH-1:0] exp_pulse(input logic [IR_W+SR_W-1:0] e, input logic act);
    logic [NCH-1:0] one;
    one = NCH'(1) << e[SR_W +: IR_W];
    return (e[SR_W-1] == act) ? one : '0;
  endfunction

  function automatic void model_push(input logic [IR_W+SR_W-1:0] e);
    if (model_q.size() >= DEPTH) model_ovf = 1'b1;
    else                         model_q.push_back(e);
  endfunction

  // Raise the chosen strobes for three cycles, then let everything settle.
  task automatic issue(input logic u, input logic d, input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data);
    ir_in  = ir;
    sr     = data;
    vs_uir = u;
    vs_udr = d;
    repeat (3) tick();
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (4) tick();
    if (d) model_push({model_irq, data});
    if (u) model_irq = ir;
  endtask

  // Pop every modelled entry one at a time, checking data, IR and pulses.
  task automatic drain_all();
    logic [IR_W+SR_W-1:0] e;
    while (model_q.size() > 0) begin
      e = model_q[0];
      check("drain_valid", 64'(cmd_valid), 64'(1));
      check("drain_level", 64'(level), 64'(model_q.size()));
      check("drain_jdo", 64'(jdo), 64'(e[SR_W-1:0]));
      check("drain_ir", 64'(cmd_ir), 64'(e[SR_W +: IR_W]));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("drain_act", 64'(take_action), 64'(exp_pulse(e, 1'b1)));
      check("drain_noact", 64'(take_no_action), 64'(exp_pulse(e, 1'b0)));
      void'(model_q.pop_front());
    end
    check("drain_empty", 64'(cmd_valid), 64'(0));
    check("drain_level0", 64'(level), 64'(0));
  endtask

  // Single command with cmd_ready held high: latency, head contents, pulse.
  task automatic single(input logic [IR_W-1:0] ir, input logic act);
    logic [SR_W-1:0] d;
    int lat;
    issue(1'b1, 1'b0, ir, rand_sr());
    d = rand_sr();
    d[SR_W-1] = act;
    d[31:0] = 32'hDEADBEEF;
    sr = d;
    cmd_ready = 1'b1;
    vs_udr = 1'b1;
    lat = 0;
    while (!cmd_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(4));
    check("single_jdo32", 64'(jdo[31:0]), 64'(32'hDEADBEEF));
    check("single_jdo", 64'(jdo), 64'(d));
    check("single_ir", 64'(cmd_ir), 64'(ir));
    vs_udr = 1'b0;
    tick();
    check("single_act", 64'(take_action), 64'(act ? (NCH'(1) << ir) : '0));
    check("single_noact", 64'(take_no_action), 64'(act ? '0 : (NCH'(1) << ir)));
    check("single_popped", 64'(cmd_valid), 64'(0));
    tick();
    check("single_act_end", 64'({take_action, take_no_action}), 64'(0));
    cmd_ready = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [SR_W-1:0] d;
    logic [IR_W+SR_W-1:0] head;
    logic [2:0] seen;

    // Reset state.
    repeat (3) tick();
    check("rst_valid", 64'(cmd_valid), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_jdo", 64'(jdo), 64'(0));
    check("rst_ir", 64'(cmd_ir), 64'(0));
    check("rst_pulses", 64'({take_action, take_no_action}), 64'(0));
    reset_n = 1'b1;
    repeat (4) tick();

    // Action on channel 2, then no-action on channel 1.
    single(2'd2, 1'b1);
    model_irq = 2'd2;
    single(2'd1, 1'b0);
    model_irq = 2'd1;

    // Overflow: five commands with random IR/data, consumer stalled.
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, IR_W'($urandom), rand_sr());
      issue(1'b0, 1'b1, ir_in, rand_sr());
    end
    check("ovf_level", 64'(level), 64'(model_q.size()));
    check("ovf_flag", 64'(overflow), 64'(model_ovf));
    drain_all();
    check("ovf_sticky", 64'(overflow), 64'(1));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'(model_ovf));

    // Full FIFO with a push landing in the same cycle as a pop.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, IR_W'($urandom), rand_sr());
      issue(1'b0, 1'b1, ir_in, rand_sr());
    end
    check("full_level", 64'(level), 64'(4));
    d = rand_sr();
    sr = d;
    vs_udr = 1'b1;
    repeat (3) tick();
    head = model_q[0];
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back({model_irq, d});
    check("coinc_level", 64'(level), 64'(4));
    check("coinc_ovf", 64'(overflow), 64'(0));
    check("coinc_act", 64'(take_action), 64'(exp_pulse(head, 1'b1)));
    check("coinc_noact", 64'(take_no_action), 64'(exp_pulse(head, 1'b0)));
    repeat (4) tick();
    drain_all();

    // Coincident uir/udr: push takes the old IR, the next push the new one.
    issue(1'b1, 1'b0, 2'd0, rand_sr());
    issue(1'b0, 1'b1, 2'd0, rand_sr());
    issue(1'b1, 1'b1, 2'd3, rand_sr());
    issue(1'b0, 1'b1, 2'd3, rand_sr());
    check("coinc_old_ir", 64'(model_q[1][SR_W +: IR_W]), 64'(0));
    drain_all();

    // Reset with three queued commands; strobe held high across release.
    for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, ir_in, rand_sr());
    check("pre_rst_level", 64'(level), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(cmd_valid), 64'(0));
    check("mid_rst_level", 64'(level), 64'(0));
    model_q.delete();
    model_irq = '0;
    model_ovf = 1'b0;
    vs_udr = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | {cmd_valid, |take_action, |take_no_action};
    end
    check("post_rst_quiet", 64'(seen), 64'(0));
    check("post_rst_level", 64'(level), 64'(0));
    vs_udr = 1'b0;
    cmd_ready = 1'b0;
    repeat (4) tick();

    // Recovery after reset: IR is back to 0.
    issue(1'b0, 1'b1, 2'd3, rand_sr());
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
